serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 113 +++++++++++
 tb/tb_serial_adder.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial unsigned adder, LSB first, one full-adder cell
// and one registered carry, one bit per clock.
//
// Optional feature macro: SERIAL_ADDER_SUB_EN adds the 'sub' port; with
// sub=1 the block computes a + ~b + 1 and y[WIDTH]=1 means a >= b.
//
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   start  - begin an operation (sampled in IDLE only)
//   a, b   - operands, captured on accepted start
//   sub    - subtract select (only with SERIAL_ADDER_SUB_EN)
//   busy   - high while bits are being processed
//   done   - one-cycle pulse, result valid on y
//   y      - WIDTH+1 bit result, y[WIDTH] is the carry-out
module serial_adder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH:0]   y
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic             carry;
   logic [CNT_W-1:0] cnt;
   logic             sub_sel;
   logic             sum_bit;
   logic             carry_nxt;

   // Subtract select; tied off when the feature is not built in.
`ifdef SERIAL_ADDER_SUB_EN
   assign sub_sel = sub;
`else
   assign sub_sel = 1'b0;
`endif

   // The single full-adder cell.
   assign sum_bit   = a_sr[0] ^ b_sr[0] ^ carry;
   assign carry_nxt = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);

   // Control FSM and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         a_sr  <= '0;
         b_sr  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         y     <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_sr  <= a;
                  // Subtraction is a + ~b + 1: invert b at capture, seed carry with 1.
                  b_sr  <= sub_sel ? ~b : b;
                  carry <= sub_sel;
                  cnt   <= '0;
                  y     <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               y[cnt] <= sum_bit;
               carry  <= carry_nxt;
               cnt    <= cnt + CNT_W'(1);
               a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
               b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
               if (cnt == LAST_BIT) begin
                  y[WIDTH] <= carry_nxt;
                  busy     <= 1'b0;
                  state    <= DONE;
               end
            end
            DONE: begin
               // Pulse is registered, so it is visible in the cycle after leaving DONE.
               done  <= 1'b1;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed-vector bench for serial_adder at WIDTH=8.
// Build with SERIAL_ADDER_SUB_EN defined to include the subtract vectors.
module tb_serial_adder;

   localparam int unsigned WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
   logic             sub;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH:0]   y;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
`ifdef SERIAL_ADDER_SUB_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .y     (y)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // One operation starting at a negedge: start accepted at the next posedge (edge 0).
   // For 'hold' cycles after acceptance start stays high with operands ja/jb.
   // lat = index k of the first cycle following edge k in which done is seen.
   task automatic op(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                     input logic [WIDTH-1:0] ja, input logic [WIDTH-1:0] jb,
                     input int hold, output logic [WIDTH:0] res,
                     output int lat, output int bcnt, output int dcnt);
      a = ia; b = ib; start = 1'b1;
      lat = -1; bcnt = 0; dcnt = 0; res = '0;
      @(posedge clk);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (k < hold) begin a = ja; b = jb; end
         else start = 1'b0;
         if (busy) bcnt++;
         if (done) begin
            dcnt++;
            if (lat < 0) begin lat = k; res = y; end
         end
      end
   endtask

   logic [WIDTH:0] res;
   int             lat, bcnt, dcnt;
   int             dt[$];

   initial begin
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
`ifdef SERIAL_ADDER_SUB_EN
      sub = 1'b0;
`endif
      repeat (2) @(negedge clk);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_y",    int'(y),    0);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic add 3+5
      op(8'd3, 8'd5, 8'd0, 8'd0, 0, res, lat, bcnt, dcnt);
      check("add_y",       int'(res), 'h008);
      check("add_busy",    bcnt, 8);
      check("add_latency", lat, 9);
      check("add_done",    dcnt, 1);
      check("add_y_hold",  int'(y), 'h008);

      // Carry-out cases
      op(8'd255, 8'd1, 8'd0, 8'd0, 0, res, lat, bcnt, dcnt);
      check("cout_255_1", int'(res), 'h100);
      op(8'd255, 8'd255, 8'd0, 8'd0, 0, res, lat, bcnt, dcnt);
      check("cout_255_255", int'(res), 'h1FE);
      check("cout_latency", lat, 9);

      // start and operand changes during RUN are ignored
      op(8'd10, 8'd20, 8'd99, 8'd99, 5, res, lat, bcnt, dcnt);
      check("ign_y",    int'(res), 'h01E);
      check("ign_done", dcnt, 1);

      // Reset in the middle of RUN
      a = 8'd7; b = 8'd9; start = 1'b1;
      @(posedge clk);
      for (int k = 0; k <= 4; k++) begin
         @(negedge clk);
         start = 1'b0;
      end
      check("mid_busy_pre", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      check("mid_busy", int'(busy), 0);
      check("mid_done", int'(done), 0);
      check("mid_y",    int'(y),    0);
      dcnt = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (k == 2) rst_n = 1'b1;
         if (done) dcnt++;
      end
      check("mid_no_done", dcnt, 0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      op(8'd1, 8'd1, 8'd0, 8'd0, 0, res, lat, bcnt, dcnt);
      check("post_rst_y",   int'(res), 'h002);
      check("post_rst_lat", lat, 9);

`ifdef SERIAL_ADDER_SUB_EN
      sub = 1'b1;
      op(8'd5, 8'd3, 8'd0, 8'd0, 0, res, lat, bcnt, dcnt);
      check("sub_5_3", int'(res), 'h102);
      op(8'd3, 8'd5, 8'd0, 8'd0, 0, res, lat, bcnt, dcnt);
      check("sub_3_5", int'(res), 'h0FE);
      sub = 1'b0;
`endif

      // Throughput: start held high for three operations
      a = 8'd1; b = 8'd2; start = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 35; k++) begin
         @(negedge clk);
         if (k == 25) start = 1'b0;
         if (done) dt.push_back(k);
      end
      check("tp_count", dt.size(), 3);
      if (dt.size() == 3) begin
         check("tp_first", dt[0], 9);
         check("tp_gap1",  dt[1] - dt[0], 10);
         check("tp_gap2",  dt[2] - dt[1], 10);
      end
      check("tp_y", int'(y), 'h003);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
